// File: rtl/fdiv_arbiter_if.sv
// ---------------------------------------------------------------------------
// fdiv_arbiter_if
// Bundles the requester-side handshake and the divider-side handshake of the
// shared floating-point divider arbiter.
//   req_valid/req_a/req_b   : per-requester strobe and packed operand slices
//   req_ready               : one-hot accept back to the requesters
//   rsp_valid/rsp_z/rsp_err : one-hot response strobe, quotient, timeout flag
//   busy                    : arbiter is not idle
//   div_a/div_b/div_valid   : operands and start pulse towards the divider
//   div_done/div_z          : completion and quotient from the divider
// The slave modport is the arbiter. The master modport is its environment
// (the requesters together with the divider).
// ---------------------------------------------------------------------------
interface fdiv_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_z;
  logic                rsp_err;
  logic                busy;
  logic [31:0]         div_a;
  logic [31:0]         div_b;
  logic                div_valid;
  logic                div_done;
  logic [31:0]         div_z;

  modport slave (
    input  req_valid, req_a, req_b, div_done, div_z,
    output req_ready, rsp_valid, rsp_z, rsp_err, busy, div_a, div_b, div_valid
  );

  modport master (
    output req_valid, req_a, req_b, div_done, div_z,
    input  req_ready, rsp_valid, rsp_z, rsp_err, busy, div_a, div_b, div_valid
  );
endinterface

// File: rtl/fdiv_arbiter.sv
// ---------------------------------------------------------------------------
// fdiv_arbiter
// Round-robin arbiter that shares one floating-point divider between N_REQ
// requesters. It runs one operation at a time: accept, issue, wait for done
// (or time out), then respond.
// Ports:
//   clk    : single clock, rising edge
//   resetn : asynchronous reset, active HIGH despite the name
//   bus    : fdiv_arbiter_if.slave (request, response and divider signals)
// Parameters:
//   N_REQ   : number of requesters (2..8)
//   TIMEOUT : WAIT cycles allowed before an error response (>=2)
// ---------------------------------------------------------------------------
module fdiv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         resetn,
  fdiv_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_INIT = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [31:0]     r_op_a;
  logic [31:0]     r_op_b;
  logic [31:0]     r_rsp_z;
  logic            r_rsp_err;
  logic [CW-1:0]   r_cnt;
  logic            w_gnt_found;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_tmo;

  assign w_tmo = (r_cnt == CNT_LAST);

  // Round-robin search: first valid requester strictly after the last grant.
  always_comb begin
    logic [IW-1:0] v_idx;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    v_idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      v_idx = IW'((int'(r_ptr) + k) % N_REQ);
      if (!w_gnt_found && bus.req_valid[v_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = v_idx;
      end else begin
        w_gnt_found = w_gnt_found;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.div_valid = 1'b0;
    bus.busy      = (r_state != ST_IDLE);
    bus.div_a     = r_op_a;
    bus.div_b     = r_op_b;
    bus.rsp_z     = r_rsp_z;
    bus.rsp_err   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        // Gate with reset so no accept is advertised while reset is held.
        if (w_gnt_found && !resetn) begin
          bus.req_ready[w_gnt_idx] = 1'b1;
          w_state_nxt              = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        bus.div_valid = 1'b1;
        w_state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.div_done || w_tmo) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        bus.rsp_valid[r_owner] = 1'b1;
        w_state_nxt            = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, wait counter and response registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_ptr     <= PTR_INIT;
      r_owner   <= '0;
      r_op_a    <= 32'd0;
      r_op_b    <= 32'd0;
      r_rsp_z   <= 32'd0;
      r_rsp_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_found) begin
            r_op_a  <= bus.req_a[{w_gnt_idx, 5'd0} +: 32];
            r_op_b  <= bus.req_b[{w_gnt_idx, 5'd0} +: 32];
            r_owner <= w_gnt_idx;
            r_ptr   <= w_gnt_idx;
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
        end
        ST_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (bus.div_done) begin
            r_rsp_z   <= bus.div_z;
            r_rsp_err <= 1'b0;
          end else if (w_tmo) begin
            r_rsp_z   <= 32'd0;
            r_rsp_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fdiv_arbiter
// Directed bench for fdiv_arbiter. A timeline model (accept cycle, issue
// cycle, done/timeout cycle, response cycle) predicts every output on every
// cycle; directed sequences add literal expectations for quotients, owners,
// grant order and latency.
// ---------------------------------------------------------------------------
module tb_fdiv_arbiter;
  localparam int N  = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  fdiv_arbiter_if #(.N_REQ(N)) bus();

  fdiv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Divider stand-in plus direct override.
  logic        stub_done, frc_done;
  logic [31:0] stub_z, frc_z;
  int          stub_cnt;
  int          stub_lat = 3;
  int          stub_mode = 0; // 0: answers after stub_lat cycles, 1: never answers
  assign bus.div_done = stub_done | frc_done;
  assign bus.div_z    = frc_done ? frc_z : stub_z;

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h3F000000}: return 32'h40400000; // 1.5/0.5 = 3
      {32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2 = 3
      {32'h3F800000, 32'h40800000}: return 32'h3E800000; // 1/4 = 0.25
      {32'h41200000, 32'h40200000}: return 32'h40800000; // 10/2.5 = 4
      {32'h40E00000, 32'h40000000}: return 32'h40600000; // 7/2 = 3.5
      {32'h41100000, 32'h40400000}: return 32'h40400000; // 9/3 = 3
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    stub_done = 1'b0;
    stub_z    = 32'd0;
    stub_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      stub_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) stub_done = 1'b1;
      end
      if (bus.div_valid && stub_mode == 0) begin
        stub_cnt = stub_lat;
        stub_z   = quot(bus.div_a, bus.div_b);
      end
    end
  end

  // ---------------- timeline model and per-cycle compare ----------------
  bit          m_inf  = 1'b0;
  int          m_iss  = 0;
  int          m_done = -1;
  int          m_owner = 0;
  int          m_last = N - 1;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_rz = 32'd0, m_pz = 32'd0;
  logic        m_re = 1'b0, m_pe = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rsp;
    logic         e_dv;
    bit           was_idle;
    int           pick;
    e_ready  = '0;
    e_rsp    = '0;
    e_dv     = 1'b0;
    pick     = -1;
    was_idle = 1'b0;
    if (resetn) begin
      m_inf = 1'b0; m_last = N - 1; m_done = -1;
      m_a = 32'd0; m_b = 32'd0; m_rz = 32'd0; m_re = 1'b0;
    end else if (m_inf) begin
      if (cyc == m_iss) begin
        e_dv = 1'b1;
      end else if (m_done < 0) begin
        // WAIT cycle number (cyc - m_iss), TO of them at most
        if (bus.div_done === 1'b1) begin
          m_done = cyc; m_pz = bus.div_z; m_pe = 1'b0;
        end else if (cyc == m_iss + TO) begin
          m_done = cyc; m_pz = 32'd0; m_pe = 1'b1;
        end
      end else if (cyc == m_done + 1) begin
        e_rsp[m_owner] = 1'b1;
        m_rz = m_pz;
        m_re = m_pe;
      end
    end else begin
      was_idle = 1'b1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && bus.req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
      end
      if (pick >= 0) e_ready[pick] = 1'b1;
    end

    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
    chk("div_valid", 32'(bus.div_valid), 32'(e_dv));
    chk("busy",      32'(bus.busy),      32'(m_inf));
    chk("div_a",     bus.div_a,          m_a);
    chk("div_b",     bus.div_b,          m_b);
    chk("rsp_z",     bus.rsp_z,          m_rz);
    chk("rsp_err",   32'(bus.rsp_err),   32'(m_re));

    if (m_inf && m_done >= 0 && cyc == m_done + 1) m_inf = 1'b0;
    if (was_idle && pick >= 0) begin
      m_inf   = 1'b1;
      m_iss   = cyc + 1;
      m_done  = -1;
      m_owner = pick;
      m_last  = pick;
      m_a     = bus.req_a[32*pick +: 32];
      m_b     = bus.req_b[32*pick +: 32];
    end
  end

  // ---------------- directed stimulus ----------------
  logic [N-1:0] s_acc, s_rsp;
  logic [31:0]  s_z;
  logic         s_err, s_dv;
  int           n_dv, n_busy, n_rsp;
  int           gq[$];

  task automatic step();
    @(negedge clk);
    s_acc = bus.req_valid & bus.req_ready;
    s_rsp = bus.rsp_valid;
    s_z   = bus.rsp_z;
    s_err = bus.rsp_err;
    s_dv  = bus.div_valid;
    if (bus.div_valid) n_dv++;
    if (bus.busy) n_busy++;
    if (bus.rsp_valid != '0) n_rsp++;
    for (int i = 0; i < N; i++) if (s_acc[i]) gq.push_back(i);
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~s_acc;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic wait_rsp(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (s_rsp != '0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no rsp_valid within 300 cycles, required one", nm);
    end
  endtask

  task automatic wait_dv(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_dv) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no div_valid within 20 cycles, required one", nm);
    end
  endtask

  task automatic pulse_reset();
    resetn = 1'b1;
    step();
    resetn = 1'b0;
  endtask

  logic [31:0] exp_z [4] = '{32'h40400000, 32'h3E800000, 32'h40800000, 32'h40600000};

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    frc_done      = 1'b0;
    frc_z         = 32'd0;

    repeat (2) step();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    resetn = 1'b0;

    // Single operation: 1.5 / 0.5
    n_dv = 0;
    set_req(0, 32'h3FC00000, 32'h3F000000);
    wait_rsp("single");
    chk("single_who", 32'(s_rsp), 32'h1);
    chk("single_z", s_z, 32'h40400000);
    chk("single_err", 32'(s_err), 32'd0);
    chk("single_dv_pulses", 32'(n_dv), 32'd1);
    repeat (2) step();

    // Contention: all four valid from the same cycle, fresh pointer
    pulse_reset();
    gq.delete();
    set_req(0, 32'h40C00000, 32'h40000000);
    set_req(1, 32'h3F800000, 32'h40800000);
    set_req(2, 32'h41200000, 32'h40200000);
    set_req(3, 32'h40E00000, 32'h40000000);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("contend");
      chk("contend_who", 32'(s_rsp), 32'(1 << k));
      chk("contend_z", s_z, exp_z[k]);
      chk("contend_err", 32'(s_err), 32'd0);
    end
    chk("contend_grants", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++) if (gq.size() > k) chk("contend_order", 32'(gq[k]), 32'(k));
    repeat (2) step();

    // Timeout: divider silent, 1 ISSUE + 64 WAIT + 1 RESP busy cycles
    stub_mode = 1;
    n_busy = 0;
    set_req(1, 32'h40C00000, 32'h40000000);
    wait_rsp("timeout");
    chk("timeout_who", 32'(s_rsp), 32'h2);
    chk("timeout_err", 32'(s_err), 32'd1);
    chk("timeout_z", s_z, 32'd0);
    chk("timeout_busy_cycles", 32'(n_busy), 32'd66);
    stub_mode = 0;
    set_req(2, 32'h41200000, 32'h40200000);
    wait_rsp("after_timeout");
    chk("after_timeout_who", 32'(s_rsp), 32'h4);
    chk("after_timeout_z", s_z, 32'h40800000);
    chk("after_timeout_err", 32'(s_err), 32'd0);

    // Done coincides with the terminal WAIT cycle
    stub_mode = 1;
    set_req(3, 32'h40E00000, 32'h40000000);
    wait_dv("coinc_issue");
    repeat (63) step();
    frc_z    = 32'h3F400000;
    frc_done = 1'b1;
    step();
    frc_done = 1'b0;
    wait_rsp("coinc");
    chk("coinc_who", 32'(s_rsp), 32'h8);
    chk("coinc_err", 32'(s_err), 32'd0);
    chk("coinc_z", s_z, 32'h3F400000);
    stub_mode = 0;

    // Reset in the middle of WAIT for requester 2
    set_req(2, 32'h3F800000, 32'h40800000);
    wait_dv("rstwait_issue");
    resetn = 1'b1;
    #1;
    chk("rstwait_busy", 32'(bus.busy), 32'd0);
    chk("rstwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstwait_div_a", bus.div_a, 32'd0);
    chk("rstwait_rsp_z", bus.rsp_z, 32'd0);
    n_rsp = 0;
    n_busy = 0;
    step();
    resetn = 1'b0;
    repeat (4) step();
    chk("rstwait_no_rsp", 32'(n_rsp), 32'd0);
    chk("rstwait_late_done_idle", 32'(n_busy), 32'd0);
    gq.delete();
    set_req(0, 32'h40C00000, 32'h40000000);
    set_req(2, 32'h3F800000, 32'h40800000);
    wait_rsp("rstwait_next0");
    chk("rstwait_next_who", 32'(s_rsp), 32'h1);
    chk("rstwait_next_z", s_z, 32'h40400000);
    if (gq.size() > 0) chk("rstwait_first_grant", 32'(gq[0]), 32'd0);
    wait_rsp("rstwait_next2");
    chk("rstwait_then_who", 32'(s_rsp), 32'h4);
    chk("rstwait_then_z", s_z, 32'h3E800000);
    repeat (2) step();

    // Spurious done while idle
    n_rsp = 0;
    n_busy = 0;
    frc_z = 32'hDEADBEEF;
    frc_done = 1'b1;
    step();
    frc_done = 1'b0;
    repeat (3) step();
    chk("spurious_no_rsp", 32'(n_rsp), 32'd0);
    chk("spurious_idle", 32'(n_busy), 32'd0);
    chk("spurious_hold_z", bus.rsp_z, 32'h3E800000);
    set_req(1, 32'h3F800000, 32'h40800000);
    set_req(3, 32'h41100000, 32'h40400000);
    wait_rsp("rr_after_2");
    chk("rr_after_2_who", 32'(s_rsp), 32'h8);
    chk("rr_after_2_z", s_z, 32'h40400000);
    wait_rsp("rr_then_1");
    chk("rr_then_1_who", 32'(s_rsp), 32'h2);
    chk("rr_then_1_z", s_z, 32'h3E800000);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
